// File: rtl/detect_map_pkg.sv
// Shared definitions for the SRAM detection map: frame geometry, bit layout,
// accumulator widths and the reader FSM states.
package detect_map_pkg;

  localparam int unsigned DEF_H_RES     = 640;
  localparam int unsigned DEF_V_RES     = 480;
  localparam int unsigned MAP_RED_BIT   = 0;
  localparam int unsigned MAP_GREEN_BIT = 1;

  // Sized for the full default frame so sums can never wrap.
  localparam int unsigned CNT_W = $clog2(DEF_H_RES * DEF_V_RES + 1);
  localparam int unsigned SUM_W = $clog2(DEF_H_RES * DEF_V_RES * DEF_H_RES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_DIV,
    S_DONE
  } dm_state_e;

  typedef struct packed {
    logic       found;
    logic [9:0] x;
    logic [8:0] y;
  } centroid_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: SUM_W-bit dividend by CNT_W-bit divisor,
// one quotient bit per cycle; o_done pulses SUM_W cycles after i_start.
module seq_divider
  import detect_map_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [SUM_W-1:0] i_dividend,
  input  logic [CNT_W-1:0] i_divisor,
  output logic             o_done,
  output logic [SUM_W-1:0] o_quotient
);

  localparam int unsigned ITER_W = $clog2(SUM_W + 1);

  logic [ITER_W-1:0] r_iter;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_div;
  logic [SUM_W-1:0]  r_quo;
  logic              r_done;
  logic [CNT_W:0]    w_shift;
  logic [CNT_W:0]    w_diff;
  logic              w_ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    w_shift = {r_rem, r_quo[SUM_W-1]};
    w_ge    = (w_shift >= {1'b0, r_div});
    w_diff  = w_shift - {1'b0, r_div};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iter <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_quo  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo  <= i_dividend;
        r_rem  <= '0;
        r_div  <= i_divisor;
        r_iter <= ITER_W'(SUM_W);
      end else if (r_iter != '0) begin
        r_quo  <= {r_quo[SUM_W-2:0], w_ge};
        r_rem  <= w_ge ? w_diff[CNT_W-1:0] : w_shift[CNT_W-1:0];
        r_iter <= r_iter - ITER_W'(1);
        if (r_iter == ITER_W'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/detect_map_reader.sv
// Scans the detection map once per frame_start and produces red/green centroids.
// Define DETECT_SUBSAMPLE_EN to read only pixels with even x and even y.
module detect_map_reader
  import detect_map_pkg::*;
#(
  parameter int unsigned H_RES      = DEF_H_RES,
  parameter int unsigned V_RES      = DEF_V_RES,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned RED_BIT    = MAP_RED_BIT,
  parameter int unsigned GREEN_BIT  = MAP_GREEN_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              result_valid,
  output logic              red_found,
  output logic [9:0]        red_x,
  output logic [8:0]        red_y,
  output logic              green_found,
  output logic [9:0]        green_x,
  output logic [8:0]        green_y
);

  localparam int unsigned X_W = $clog2(H_RES);
  localparam int unsigned Y_W = $clog2(V_RES);
`ifdef DETECT_SUBSAMPLE_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif
  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_RES - STEP);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_RES - STEP);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STEP * H_RES);

  dm_state_e         r_state;
  dm_state_e         w_state_nxt;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_hit_red;
  logic              r_hit_grn;
  logic [CNT_W-1:0]  r_red_cnt;
  logic [CNT_W-1:0]  r_grn_cnt;
  logic [SUM_W-1:0]  r_red_sx;
  logic [SUM_W-1:0]  r_red_sy;
  logic [SUM_W-1:0]  r_grn_sx;
  logic [SUM_W-1:0]  r_grn_sy;
  logic [1:0]        r_div_idx;
  logic              r_div_busy;
  logic [9:0]        r_q_rx;
  logic [8:0]        r_q_ry;
  logic [9:0]        r_q_gx;
  logic [8:0]        r_q_gy;
  centroid_t         r_red;
  centroid_t         r_grn;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_busy;
  logic              r_result_valid;

  logic              w_last_px;
  logic              w_red_ok;
  logic              w_grn_ok;
  logic              w_skip;
  logic              w_div_start;
  logic              w_div_adv;
  logic              w_div_done;
  logic [SUM_W-1:0]  w_dividend;
  logic [CNT_W-1:0]  w_divisor;
  logic [SUM_W-1:0]  w_quo;
  logic [8:0]        w_q_gy_nxt;
  logic              w_unused;

  assign w_last_px = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_red_ok  = (r_red_cnt >= CNT_W'(MIN_PIXELS));
  assign w_grn_ok  = (r_grn_cnt >= CNT_W'(MIN_PIXELS));
  assign w_unused  = ^{rd_data, w_quo};

  // Operand select for the shared divider: red_x, red_y, green_x, green_y.
  always_comb begin
    w_dividend = r_red_sx;
    w_divisor  = r_red_cnt;
    w_skip     = !w_red_ok;
    case (r_div_idx)
      2'd1: w_dividend = r_red_sy;
      2'd2: begin
        w_dividend = r_grn_sx;
        w_divisor  = r_grn_cnt;
        w_skip     = !w_grn_ok;
      end
      2'd3: begin
        w_dividend = r_grn_sy;
        w_divisor  = r_grn_cnt;
        w_skip     = !w_grn_ok;
      end
      default: ;
    endcase
  end

  // The last quotient lands on the same edge the outputs are loaded.
  assign w_q_gy_nxt = (r_div_busy && w_div_done && (r_div_idx == 2'd3)) ? 9'(w_quo) : r_q_gy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    w_div_adv   = 1'b0;
    case (r_state)
      S_IDLE:  if (frame_start) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (rd_valid) w_state_nxt = S_ACC;
      S_ACC:   w_state_nxt = w_last_px ? S_DIV : S_ISSUE;
      S_DIV: begin
        if (!r_div_busy) begin
          if (w_skip) w_div_adv = 1'b1;
          else        w_div_start = 1'b1;
        end else if (w_div_done) begin
          w_div_adv = 1'b1;
        end
        if (w_div_adv && (r_div_idx == 2'd3)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x            <= '0;
      r_y            <= '0;
      r_row_base     <= '0;
      r_hit_red      <= 1'b0;
      r_hit_grn      <= 1'b0;
      r_red_cnt      <= '0;
      r_grn_cnt      <= '0;
      r_red_sx       <= '0;
      r_red_sy       <= '0;
      r_grn_sx       <= '0;
      r_grn_sy       <= '0;
      r_div_idx      <= '0;
      r_div_busy     <= 1'b0;
      r_q_rx         <= '0;
      r_q_ry         <= '0;
      r_q_gx         <= '0;
      r_q_gy         <= '0;
      r_red          <= '0;
      r_grn          <= '0;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_rd_en        <= (r_state == S_ISSUE);
      r_busy         <= (w_state_nxt inside {S_ISSUE, S_WAIT, S_ACC, S_DIV});
      r_result_valid <= (w_state_nxt == S_DONE);
      if (r_state == S_ISSUE) r_rd_addr <= r_row_base + ADDR_W'(r_x);

      case (r_state)
        S_IDLE: if (frame_start) begin
          r_x        <= '0;
          r_y        <= '0;
          r_row_base <= '0;
          r_red_cnt  <= '0;
          r_grn_cnt  <= '0;
          r_red_sx   <= '0;
          r_red_sy   <= '0;
          r_grn_sx   <= '0;
          r_grn_sy   <= '0;
          r_div_idx  <= '0;
          r_div_busy <= 1'b0;
        end
        S_WAIT: if (rd_valid) begin
          r_hit_red <= rd_data[RED_BIT];
          r_hit_grn <= rd_data[GREEN_BIT];
        end
        S_ACC: begin
          if (r_hit_red) begin
            r_red_cnt <= r_red_cnt + CNT_W'(1);
            r_red_sx  <= r_red_sx + SUM_W'(r_x);
            r_red_sy  <= r_red_sy + SUM_W'(r_y);
          end
          if (r_hit_grn) begin
            r_grn_cnt <= r_grn_cnt + CNT_W'(1);
            r_grn_sx  <= r_grn_sx + SUM_W'(r_x);
            r_grn_sy  <= r_grn_sy + SUM_W'(r_y);
          end
          if (r_x == X_LAST) begin
            r_x        <= '0;
            r_y        <= r_y + Y_W'(STEP);
            r_row_base <= r_row_base + ROW_STEP;
          end else begin
            r_x <= r_x + X_W'(STEP);
          end
        end
        S_DIV: begin
          if (w_div_start) r_div_busy <= 1'b1;
          if (r_div_busy && w_div_done) begin
            r_div_busy <= 1'b0;
            case (r_div_idx)
              2'd0:    r_q_rx <= 10'(w_quo);
              2'd1:    r_q_ry <= 9'(w_quo);
              2'd2:    r_q_gx <= 10'(w_quo);
              default: r_q_gy <= 9'(w_quo);
            endcase
          end
          if (w_div_adv) r_div_idx <= r_div_idx + 2'd1;
        end
        default: ;
      endcase

      // Publish centroids; a colour below threshold keeps its last coordinates.
      if (w_state_nxt == S_DONE) begin
        r_red.found <= w_red_ok;
        r_grn.found <= w_grn_ok;
        if (w_red_ok) begin
          r_red.x <= r_q_rx;
          r_red.y <= r_q_ry;
        end
        if (w_grn_ok) begin
          r_grn.x <= r_q_gx;
          r_grn.y <= w_q_gy_nxt;
        end
      end
    end
  end

  seq_divider u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign red_found    = r_red.found;
  assign red_x        = r_red.x;
  assign red_y        = r_red.y;
  assign green_found  = r_grn.found;
  assign green_x      = r_grn.x;
  assign green_y      = r_grn.y;

endmodule

// File: tb/tb_detect_map_reader.sv
// Bench for detect_map_reader on a reduced 32x24 frame with a latency-randomised SRAM model.
module tb_detect_map_reader;

  localparam int H  = 32;
  localparam int V  = 24;
  localparam int AW = 20;
  localparam int DW = 16;
`ifdef DETECT_SUBSAMPLE_EN
  localparam int STEP  = 2;
  localparam int MINP  = 4;
  localparam int T2_RY = 7;
`else
  localparam int STEP  = 1;
  localparam int MINP  = 16;
  localparam int T2_RY = 6;
`endif
  localparam int NPIX   = H * V;
  localparam int COLS   = H / STEP;
  localparam int NREAD  = COLS * (V / STEP);
  localparam int BUDGET = NREAD * 10 + 400;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          rd_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          result_valid;
  logic          red_found;
  logic [9:0]    red_x;
  logic [8:0]    red_y;
  logic          green_found;
  logic [9:0]    green_x;
  logic [8:0]    green_y;

  logic [15:0] mem [NPIX];
  int total = 0;
  int bad = 0;
  int lat_max = 1;
  int nreads = 0;
  int rv_cnt = 0;
  int addr_err = 0;
  int scan_base = 0;
  int mon_idx;
  int mon_exp;

  logic       e_rf = 1'b0;
  logic       e_gf = 1'b0;
  logic [9:0] e_rx = '0;
  logic [8:0] e_ry = '0;
  logic [9:0] e_gx = '0;
  logic [8:0] e_gy = '0;

  always #5 clk = ~clk;

  detect_map_reader #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW),
    .MIN_PIXELS(MINP), .RED_BIT(0), .GREEN_BIT(1)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .result_valid(result_valid),
    .red_found(red_found), .red_x(red_x), .red_y(red_y),
    .green_found(green_found), .green_x(green_x), .green_y(green_y)
  );

  // SRAM responder: one strobe 1..lat_max cycles after each request.
  initial begin
    int a;
    int lat;
    forever begin
      @(negedge clk);
      if (reset && rd_en) begin
        a   = int'(rd_addr);
        lat = $urandom_range(1, lat_max);
        repeat (lat) @(posedge clk);
        #1;
        rd_valid = 1'b1;
        rd_data  = (a < NPIX) ? mem[a] : 16'hdead;
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rd_data  = 16'($urandom);
      end
    end
  end

  // Read-order monitor: raster order, stepping by STEP in x and y.
  always @(negedge clk) begin
    if (reset && rd_en) begin
      mon_idx = nreads - scan_base;
      mon_exp = (mon_idx / COLS) * STEP * H + (mon_idx % COLS) * STEP;
      if (rd_addr !== AW'(mon_exp)) addr_err = addr_err + 1;
      nreads = nreads + 1;
    end
    if (reset && result_valid) rv_cnt = rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: centroids straight from the map contents.
  task automatic model_scan();
    longint rc = 0, gc = 0, rsx = 0, rsy = 0, gsx = 0, gsy = 0;
    logic [15:0] w;
    for (int y = 0; y < V; y += STEP) begin
      for (int x = 0; x < H; x += STEP) begin
        w = mem[y * H + x];
        if (w[0]) begin rc++; rsx += x; rsy += y; end
        if (w[1]) begin gc++; gsx += x; gsy += y; end
      end
    end
    e_rf = (rc >= MINP);
    e_gf = (gc >= MINP);
    if (e_rf) begin e_rx = 10'(rsx / rc); e_ry = 9'(rsy / rc); end
    if (e_gf) begin e_gx = 10'(gsx / gc); e_gy = 9'(gsy / gc); end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = 16'h0;
  endtask

  task automatic fill_block(input int x0, input int y0, input logic [15:0] w);
    for (int y = y0; y < y0 + 4; y++)
      for (int x = x0; x < x0 + 4; x++) mem[y * H + x] = w;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rf"}, 64'(red_found), 64'(e_rf));
    chk({tag, "_rx"}, 64'(red_x), 64'(e_rx));
    chk({tag, "_ry"}, 64'(red_y), 64'(e_ry));
    chk({tag, "_gf"}, 64'(green_found), 64'(e_gf));
    chk({tag, "_gx"}, 64'(green_x), 64'(e_gx));
    chk({tag, "_gy"}, 64'(green_y), 64'(e_gy));
  endtask

  task automatic run_scan(input string tag, input bit inject);
    int  cyc = 0;
    int  rv_base;
    bit  got = 1'b0;
    @(negedge clk);
    scan_base   = nreads;
    rv_base     = rv_cnt;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk({tag, "_busy_hi"}, 64'(busy), 64'(1));
    while (!got && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (result_valid) got = 1'b1;
      else frame_start = inject && ($urandom_range(0, 63) == 0);
    end
    chk({tag, "_done"}, 64'(got), 64'(1));
    if (got) begin
      check_outputs(tag);
      chk({tag, "_busy_lo"}, 64'(busy), 64'(0));
    end
    frame_start = inject;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (40) @(negedge clk);
    chk({tag, "_rv_once"}, 64'(rv_cnt - rv_base), 64'(1));
    chk({tag, "_reads"}, 64'(nreads - scan_base), 64'(NREAD));
    chk({tag, "_addr"}, 64'(addr_err), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({rd_en, rd_addr, busy, result_valid, red_found, red_x, red_y,
                green_found, green_x, green_y});
  endfunction

  initial begin
    int c;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset_outs", out_vec(), 64'(0));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    // all-zero map
    model_scan();
    run_scan("t1_zero", 1'b0);

    // red 4x4 block
    fill_block(10, 5, 16'h0001);
    model_scan();
    run_scan("t2_block", 1'b0);
    chk("t2_rx_const", 64'(red_x), 64'(11));
    chk("t2_ry_const", 64'(red_y), 64'(T2_RY));

    // one pixel short of threshold: found drops, coords hold
    mem[8 * H + 12] = 16'h0000;
    model_scan();
    run_scan("t3_short", 1'b0);
    chk("t3_rf_const", 64'(red_found), 64'(0));
    chk("t3_rx_held", 64'(red_x), 64'(11));

    // both colours on the same words
    clear_mem();
    fill_block(20, 12, 16'h0003);
    model_scan();
    run_scan("t4_both", 1'b0);
    chk("t4_rx_const", 64'(red_x), 64'(21));
    chk("t4_ry_const", 64'(red_y), 64'(13));
    chk("t4_gx_const", 64'(green_x), 64'(21));
    chk("t4_gy_const", 64'(green_y), 64'(13));

    // random maps, random latency, stray frame_start pulses
    lat_max = 6;
    for (int i = 0; i < NPIX; i++)
      mem[i] = (16'($urandom) & 16'hfffc) |
               {14'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
    model_scan();
    run_scan("t5_dense", 1'b1);
    for (int i = 0; i < NPIX; i++) mem[i] = mem[i] & 16'hfffd;
    mem[2 * H + 4]  = mem[2 * H + 4] | 16'h0002;
    mem[6 * H + 8]  = mem[6 * H + 8] | 16'h0002;
    mem[10 * H + 2] = mem[10 * H + 2] | 16'h0002;
    model_scan();
    run_scan("t5_sparse", 1'b1);
    lat_max = 1;
    run_scan("t5_fixed", 1'b0);

    // reset in the middle of a scan
    for (int i = 0; i < NPIX; i++)
      mem[i] = {14'b0, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)};
    @(negedge clk);
    scan_base   = nreads;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    c = 0;
    while ((nreads - scan_base) < 300 && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reached", 64'((nreads - scan_base) >= 300), 64'(1));
    reset = 1'b0;
    #1;
    chk("t6_rst_outs", out_vec(), 64'(0));
    e_rf = 1'b0; e_gf = 1'b0; e_rx = '0; e_ry = '0; e_gx = '0; e_gy = '0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_result", 64'(result_valid), 64'(0));
    model_scan();
    run_scan("t6_after", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
